// File: rtl/pcm_sample_player.sv
// pcm_sample_player: fetches PCM samples on each sample_tick from a synchronous-read memory, holds them, and drives a PWM output.
// Optional macro PCM_PLAYER_OVERRUN_CNT_EN enables the saturating lost-tick counter on overrun_cnt.
`default_nettype none

module pcm_sample_player #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic [7:0]        overrun_cnt,
  output logic              pwm_out
);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_READ, S_LATCH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d, start_q, start_d, end_q, end_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                pending_q, pending_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   pwm_cnt_q;
  logic                pwm_q;
  logic                lost, accept, latch;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    start_d   = start_q;
    end_d     = end_q;
    pending_d = pending_q;
    lost      = 1'b0;
    accept    = 1'b0;
    latch     = 1'b0;
    if (stop) begin
      state_d   = S_IDLE;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pending_d = 1'b0;
          if (start && (start_addr <= end_addr)) begin
            accept  = 1'b1;
            start_d = start_addr;
            end_d   = end_addr;
            cur_d   = start_addr;
            state_d = S_READY;
          end
        end
        S_READY: begin
          if (sample_tick || pending_q) begin
            state_d   = S_READ;
            pending_d = 1'b0;
            // a fresh tick arriving alongside a pending one cannot both be served
            lost      = sample_tick && pending_q;
          end
        end
        S_READ: begin
          state_d = S_LATCH;
          if (sample_tick) begin
            if (pending_q) lost = 1'b1;
            else           pending_d = 1'b1;
          end
        end
        default: begin
          latch = 1'b1;
          if (sample_tick) begin
            if (pending_q) lost = 1'b1;
            else           pending_d = 1'b1;
          end
          if (cur_q != end_q) begin
            cur_d   = cur_q + 1'b1;
            state_d = S_READY;
          end else if (loop_en) begin
            cur_d   = start_q;
            state_d = S_READY;
          end else begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
          end
        end
      endcase
    end
    mem_rd_d   = (state_d == S_READ);
    mem_addr_d = (state_d == S_READ) ? cur_q : mem_addr_q;
    sample_d   = latch ? mem_data : sample_q;
    valid_d    = latch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      pending_q  <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      pwm_cnt_q  <= '0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      start_q    <= start_d;
      end_q      <= end_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      pending_q  <= pending_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      pwm_cnt_q  <= pwm_cnt_q + DATA_W'(1);
      pwm_q      <= (pwm_cnt_q < sample_q);
    end
  end

`ifdef PCM_PLAYER_OVERRUN_CNT_EN
  logic [7:0] overrun_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overrun_q <= '0;
    else if (accept)                     overrun_q <= '0;
    else if (lost && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
  end
  assign overrun_cnt = overrun_q;
`else
  logic [1:0] unused_overrun;
  assign unused_overrun = {lost, accept};
  assign overrun_cnt    = '0;
`endif

  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != S_IDLE);
  assign pwm_out      = pwm_q;

endmodule

`default_nettype wire
